// File: rtl/sint2fp.sv
// sint2fp: serial signed int32 -> IEEE-754 single converter, normalising one bit per cycle.
// Build option: define SINT2FP_RNE_EN for round-to-nearest-even; default build truncates.
module sint2fp (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  cnt;
    logic [31:0] abs_in;
    logic [7:0]  exp_base;
    logic [7:0]  exp_r;
    logic [22:0] frac_r;
    logic        accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    // -2^31 negates to itself, which is exactly the unsigned magnitude wanted
    assign abs_in   = in_data[31] ? (~in_data + 32'd1) : in_data;
    assign exp_base = 8'd158 - {3'b000, cnt};

`ifdef SINT2FP_RNE_EN
    logic        guard;
    logic        sticky;
    logic        rnd_inc;
    logic [23:0] frac_sum;

    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign rnd_inc  = guard & (sticky | mag[8]);
    assign frac_sum = {1'b0, mag[30:8]} + {23'd0, rnd_inc};
    // a carry leaves frac_sum[22:0] at zero and bumps the exponent (max 159)
    assign frac_r   = frac_sum[22:0];
    assign exp_r    = exp_base + {7'd0, frac_sum[23]};
`else
    assign frac_r   = mag[30:8];
    assign exp_r    = exp_base;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (in_data == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_valid & out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign      <= 1'b0;
            mag       <= 32'd0;
            cnt       <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= in_data[31];
                        mag  <= abs_in;
                        cnt  <= 5'd0;
                        if (in_data == 32'd0) begin
                            out_data  <= 32'd0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        cnt <= cnt + 5'd1;
                    end
                end
                ROUND: begin
                    out_data  <= {sign, exp_r, frac_r};
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
